// File: rtl/inst_fetch.sv
// inst_fetch
//   Instruction fetch stage. Owns the PC, issues one fetch at a time over an
//   SRAM-like req/addr_ok/data_ok port and presents {pc, inst} to decode
//   with a valid/ready handshake. A redirect from decode (br_taken_i) moves
//   the PC and squashes any wrong-path fetch that is in flight or held.
//
// Ports
//   clk             clock, rising edge
//   rst_n           async active-low reset
//   br_taken_i      redirect pulse from decode (one cycle)
//   br_target_i     redirect PC, qualified by br_taken_i
//   inst_req_o      fetch request
//   inst_addr_o     fetch address (always the current PC)
//   inst_addr_ok_i  request accepted this cycle
//   inst_data_ok_i  read data returned this cycle
//   inst_rdata_i    returned instruction
//   if_valid_o      {if_pc_o, if_inst_o} valid to decode
//   if_ready_i      decode accepts this cycle
//   if_pc_o         pc of presented instruction
//   if_inst_o       presented instruction
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | first cycle after reset release
// REQ    | request driven at pc, waiting for addr_ok
// WAIT   | request accepted, waiting for data_ok (drop it if discard_q)
// HOLD   | instruction presented to decode, waiting for if_ready
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h1c000000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  br_taken_i,
  input  logic [ADDR_WIDTH-1:0] br_target_i,
  output logic                  inst_req_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                  inst_addr_ok_i,
  input  logic                  inst_data_ok_i,
  input  logic [INST_WIDTH-1:0] inst_rdata_i,
  output logic                  if_valid_o,
  input  logic                  if_ready_i,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [INST_WIDTH-1:0] if_inst_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    discard_q, discard_d;
  logic [ADDR_WIDTH-1:0]   if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0]   if_inst_q, if_inst_d;
  logic                    inst_req_q;
  logic                    if_valid_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (br_taken_i) pc_d = br_target_i;
      end
      S_REQ: begin
        if (br_taken_i) pc_d = br_target_i;
        if (inst_addr_ok_i) begin
          state_d = S_WAIT;
          // The old address was already accepted; its data is wrong-path.
          if (br_taken_i) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_data_ok_i) begin
          if (br_taken_i) begin
            pc_d      = br_target_i;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            if_pc_d   = pc_q;
            if_inst_d = inst_rdata_i;
            pc_d      = pc_q + ADDR_WIDTH'(4);
            state_d   = S_HOLD;
          end
        end else if (br_taken_i) begin
          pc_d      = br_target_i;
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (br_taken_i) begin
          pc_d    = br_target_i;
          state_d = S_REQ;
        end else if (if_ready_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      discard_q  <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      inst_req_q <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      discard_q  <= discard_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      inst_req_q <= (state_d == S_REQ);
      if_valid_q <= (state_d == S_HOLD);
    end
  end

  assign inst_req_o  = inst_req_q;
  assign inst_addr_o = pc_q;
  // A redirect in HOLD makes the held instruction wrong-path, so it must not
  // complete a handshake in that same cycle.
  assign if_valid_o  = if_valid_q & ~br_taken_i;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;

  a_data_ok_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n) inst_data_ok_i |-> (state_q == S_WAIT));

  a_req_valid_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(inst_req_o && if_valid_o));

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] DEAD     = 32'hDEADBEEF;
  localparam logic [31:0] NONE     = 32'hBAD00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_taken_i     (br_taken),
    .br_target_i    (br_target),
    .inst_req_o     (inst_req),
    .inst_addr_o    (inst_addr),
    .inst_addr_ok_i (inst_addr_ok),
    .inst_data_ok_i (inst_data_ok),
    .inst_rdata_i   (inst_rdata),
    .if_valid_o     (if_valid),
    .if_ready_i     (if_ready),
    .if_pc_o        (if_pc),
    .if_inst_o      (if_inst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
  endfunction

  // Reference model: the pc the next instruction handed to decode must carry.
  // Sequential flow adds 4 per accepted instruction; a redirect replaces it.
  logic [31:0] exp_q[$];

  // Stimulus knobs
  int          ack_pct = 100, lat_min = 0, lat_max = 0, rdy_pct = 100, br_pct = 0;
  int          arm = 0;
  logic [31:0] arm_tgt = '0;
  bit          dead_mode = 0;
  int          cyc = 0;

  // Memory-side state
  bit          pend = 0;
  logic [31:0] p_addr = '0;
  int          p_lat = 0;
  logic [31:0] addr_log[$];
  int          acc_cyc[$];
  int          val_cyc[$];
  bit          pre_acc = 0, pre_dok = 0;
  logic [31:0] pre_addr = '0;

  function automatic logic [31:0] qat(input int i);
    if (i >= 0 && i < addr_log.size()) return addr_log[i];
    return NONE;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (pre_dok) pend = 0;
    if (pre_acc) begin
      pend   = 1;
      p_addr = pre_addr;
      p_lat  = int'($urandom_range(lat_max, lat_min));
      addr_log.push_back(pre_addr);
      acc_cyc.push_back(cyc - 1);
    end
    #1;
    br_taken     = 1'b0;
    br_target    = $urandom;
    inst_addr_ok = inst_req && (int'($urandom_range(99, 0)) < ack_pct);
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (pend) begin
      if (p_lat == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = dead_mode ? DEAD : memf(p_addr);
        dead_mode    = 0;
      end else begin
        p_lat--;
      end
    end
    if_ready = (int'($urandom_range(99, 0)) < rdy_pct);
    if (arm == 1 && inst_req) begin
      br_taken = 1'b1; br_target = arm_tgt; inst_addr_ok = 1'b1; arm = 0;
    end else if (arm == 2 && pend && !inst_data_ok) begin
      br_taken = 1'b1; br_target = arm_tgt; dead_mode = 1; arm = 0;
    end else if (arm == 3) begin
      br_taken = 1'b1; br_target = arm_tgt; arm = 0;
    end else if (int'($urandom_range(99, 0)) < br_pct) begin
      br_taken = 1'b1; br_target = $urandom & 32'hFFFFFFFC;
    end
    if (br_taken) begin
      exp_q.delete();
      exp_q.push_back(br_target);
    end
    #3;
    pre_acc  = inst_req && inst_addr_ok;
    pre_dok  = inst_data_ok;
    pre_addr = inst_addr;
    if (if_valid) val_cyc.push_back(cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pend = 0; pre_acc = 0; pre_dok = 0; dead_mode = 0; arm = 0;
    br_taken = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; if_ready = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    addr_log.delete(); acc_cyc.delete(); val_cyc.delete();
    #1;
    chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    bit pv_unacc, pv_acc;
    logic [31:0] pv_addr, e;
    int idle_cnt;
    pv_unacc = 0; pv_acc = 0; pv_addr = '0; idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_unacc = 0; pv_acc = 0; idle_cnt = 0;
        continue;
      end
      chk("req_valid_excl", {31'b0, inst_req && if_valid}, 32'd0);
      if (br_taken) chk("valid_gated_by_br", {31'b0, if_valid}, 32'd0);
      if (pv_unacc) begin
        chk("req_held", {31'b0, inst_req}, 32'd1);
        chk("addr_stable", inst_addr, pv_addr);
      end
      if (pv_acc) chk("req_drop_after_accept", {31'b0, inst_req}, 32'd0);
      if (if_valid) begin
        n_checks++;
        if (if_inst == DEAD) begin
          n_fail++;
          $display("FAIL squashed_data_presented actual=%h pc=%h", if_inst, if_pc);
        end
      end
      if (if_valid && if_ready) begin
        idle_cnt = 0;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_underflow actual_pc=%h expected=none", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e);
          chk("if_inst", if_inst, memf(e));
          exp_q.push_back(e + 32'd4);
        end
      end else begin
        idle_cnt++;
        if (idle_cnt > 300) begin
          n_checks++; n_fail++;
          $display("FAIL watchdog actual=no_handshake_300_cycles expected=progress");
          idle_cnt = 0;
        end
      end
      pv_unacc = inst_req && !inst_addr_ok && !br_taken;
      pv_acc   = inst_req && inst_addr_ok;
      pv_addr  = inst_addr;
    end
  end

  initial begin
    logic [31:0] a0, hpc, hinst;
    int n, k;
    bit ok;

    do_reset();

    // 1: streaming with immediate memory
    ack_pct = 100; lat_min = 0; lat_max = 0; rdy_pct = 100; br_pct = 0;
    repeat (12) step();
    chk("p1_addr0", qat(0), RESET_PC);
    chk("p1_addr1", qat(1), RESET_PC + 32'd4);
    chk("p1_addr2", qat(2), RESET_PC + 32'd8);
    if (acc_cyc.size() > 0 && val_cyc.size() > 1) begin
      chk("p1_latency", 32'(val_cyc[0] - acc_cyc[0]), 32'd2);
      chk("p1_throughput", 32'(val_cyc[1] - val_cyc[0]), 32'd3);
    end else begin
      chk("p1_progress", 32'(val_cyc.size()), 32'd2);
    end

    // 2: request not accepted for several cycles
    ack_pct = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (inst_req) begin ok = 1; break; end
    end
    chk("p2_req_seen", {31'b0, ok}, 32'd1);
    a0 = inst_addr;
    repeat (4) begin
      step();
      chk("p2_req_held", {31'b0, inst_req}, 32'd1);
      chk("p2_addr_held", inst_addr, a0);
    end
    ack_pct = 100;
    step();
    step();
    chk("p2_in_wait", {31'b0, inst_req}, 32'd0);

    // 3: redirect while waiting for data that arrives later
    lat_min = 2; lat_max = 2;
    arm = 2; arm_tgt = 32'h1c000100;
    for (int i = 0; i < 50 && arm != 0; i++) step();
    chk("p3_armed", 32'(arm), 32'd0);
    lat_min = 0; lat_max = 0;
    n = addr_log.size();
    for (int i = 0; i < 50 && addr_log.size() <= n; i++) step();
    chk("p3_next_addr", qat(n), 32'h1c000100);
    repeat (6) step();

    // 4: redirect in the same cycle the request is accepted
    lat_min = 1; lat_max = 1;
    arm = 1; arm_tgt = 32'h1c000300;
    for (int i = 0; i < 50 && arm != 0; i++) step();
    chk("p4_armed", 32'(arm), 32'd0);
    step();
    n = addr_log.size();
    for (int i = 0; i < 50 && addr_log.size() <= n; i++) step();
    chk("p4_next_addr", qat(n), 32'h1c000300);
    lat_min = 0; lat_max = 0;
    repeat (6) step();

    // 5: decode stalls, then redirects over the held instruction
    rdy_pct = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (if_valid) begin ok = 1; break; end
    end
    chk("p5_valid_seen", {31'b0, ok}, 32'd1);
    hpc = if_pc; hinst = if_inst;
    repeat (5) begin
      step();
      chk("p5_valid_held", {31'b0, if_valid}, 32'd1);
      chk("p5_pc_held", if_pc, hpc);
      chk("p5_inst_held", if_inst, hinst);
      chk("p5_no_req", {31'b0, inst_req}, 32'd0);
    end
    rdy_pct = 100;
    arm = 3; arm_tgt = 32'h1c000200;
    step();
    chk("p5_br_gates_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("p5_req_after_br", {31'b0, inst_req}, 32'd1);
    chk("p5_addr_after_br", inst_addr, 32'h1c000200);

    // 6: pc wrap, then reset mid-WAIT
    arm = 3; arm_tgt = 32'hFFFFFFFC;
    repeat (14) step();
    k = -1;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] == 32'hFFFFFFFC) k = i;
    chk("p6_wrap_fetched", {31'b0, k >= 0}, 32'd1);
    chk("p6_wrap_next", qat(k + 1), 32'h0);
    lat_min = 3; lat_max = 3;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (pend && !inst_req && !inst_data_ok) begin ok = 1; break; end
    end
    chk("p6_in_wait", {31'b0, ok}, 32'd1);
    lat_min = 0; lat_max = 0;
    do_reset();
    repeat (8) step();
    chk("p6_restart_addr0", qat(0), RESET_PC);
    chk("p6_restart_addr1", qat(1), RESET_PC + 32'd4);

    // Randomized traffic
    for (int b = 0; b < 40; b++) begin
      ack_pct = int'($urandom_range(100, 30));
      lat_min = 0;
      lat_max = int'($urandom_range(3, 0));
      rdy_pct = int'($urandom_range(100, 20));
      br_pct  = int'($urandom_range(10, 0));
      repeat (40) step();
    end
    br_pct = 0; ack_pct = 100; rdy_pct = 100; lat_max = 0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
